// File: rtl/wid_union_unpacker_if.sv
// Handshake bundle for the lane unpacker: word-in channel, lane-beat-out channel, error pulse.
interface wid_union_unpacker_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_lane;
  logic        out_last;
  logic        err_mode;

  modport master (
    output in_valid, in_word, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last, err_mode
  );

  modport slave (
    input  in_valid, in_word, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last, err_mode
  );
endinterface

// File: rtl/wid_union_unpacker.sv
// Splits a 32-bit word into 1/2/4 zero-extended lane beats; first beat one cycle after accept.
// Backpressure: beats hold while out_ready is low; a new word is taken only as the last beat leaves.
module wid_union_unpacker #(
  parameter int LANE_ORDER = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wid_union_unpacker_if.slave  bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  beat_q, beat_d;
  logic        err_q, err_d;

  logic [1:0]  last_idx;
  logic [1:0]  lane;
  logic [31:0] lane_dat;
  logic        emit, is_last, out_hs, in_rdy, in_hs;

  always_comb begin
    last_idx = 2'd3;
    case (mode_q)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  // beat_q counts beats already sent; the lane index is derived from it per ordering
  assign lane    = (LANE_ORDER != 0) ? (last_idx - beat_q) : beat_q;
  assign emit    = (state_q == S_EMIT);
  assign is_last = emit && (beat_q == last_idx);
  assign out_hs  = emit && bus.out_ready;
  assign in_rdy  = rst_n && (!emit || (out_hs && is_last));
  assign in_hs   = bus.in_valid && in_rdy;

  always_comb begin
    lane_dat = 32'd0;
    case (mode_q)
      2'b00:   lane_dat = word_q;
      2'b01:   lane_dat = lane[0] ? {16'd0, word_q[31:16]} : {16'd0, word_q[15:0]};
      default: lane_dat = {24'd0, word_q[{lane, 3'b000} +: 8]};
    endcase
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = emit;
  assign bus.out_data  = emit ? lane_dat : 32'd0;
  assign bus.out_lane  = emit ? lane : 2'd0;
  assign bus.out_last  = is_last;
  assign bus.err_mode  = err_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mode_d  = mode_q;
    beat_d  = beat_q;
    err_d   = 1'b0;
    if (out_hs) begin
      if (is_last) state_d = S_IDLE;
      else         beat_d  = beat_q + 2'd1;
    end
    // an accept can only coincide with a last-beat handshake, so it overrides the above
    if (in_hs) begin
      if (bus.in_mode == 2'b11) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        state_d = S_EMIT;
        word_d  = bus.in_word;
        mode_d  = bus.in_mode;
        beat_d  = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      word_q  <= 32'd0;
      mode_q  <= 2'b00;
      beat_q  <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mode_q  <= mode_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_wid_union_unpacker.sv
// Drives two unpackers (lane order 0 and 1) with identical stimulus and checks them against a beat-queue model.
module tb_wid_union_unpacker;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_word;
  logic [1:0]  in_mode;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] dat;
    logic [1:0]  lane;
    logic        last;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  logic  err_exp;

  wid_union_unpacker_if if0 ();
  wid_union_unpacker_if if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_word   = in_word;
  assign if0.in_mode   = in_mode;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.in_word   = in_word;
  assign if1.in_mode   = in_mode;
  assign if1.out_ready = out_ready;

  wid_union_unpacker #(.LANE_ORDER(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  wid_union_unpacker #(.LANE_ORDER(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void push_word(input logic [31:0] w, input logic [1:0] m);
    int n, bits;
    longint unsigned mask;
    beat_t b;
    n    = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
    bits = 32 / n;
    mask = (64'd1 << bits) - 1;
    for (int i = 0; i < n; i++) begin
      b.last = (i == n - 1);
      b.lane = 2'(i);
      b.dat  = 32'((longint'(w) >> (bits * i)) & mask);
      q0.push_back(b);
      b.lane = 2'(n - 1 - i);
      b.dat  = 32'((longint'(w) >> (bits * (n - 1 - i))) & mask);
      q1.push_back(b);
    end
  endfunction

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    logic exp_rdy, hs_in, hs_out, vld;
    @(negedge clk);
    vld     = (q0.size() != 0);
    exp_rdy = rst_n && (!vld || (q0.size() == 1 && out_ready));
    chk("in_ready0", if0.in_ready, exp_rdy);
    chk("in_ready1", if1.in_ready, exp_rdy);
    chk("out_valid0", if0.out_valid, vld);
    chk("out_valid1", if1.out_valid, vld);
    chk("err_mode0", if0.err_mode, err_exp);
    chk("err_mode1", if1.err_mode, err_exp);
    if (vld) begin
      chk("out_data0", if0.out_data, q0[0].dat);
      chk("out_lane0", if0.out_lane, q0[0].lane);
      chk("out_last0", if0.out_last, q0[0].last);
      chk("out_data1", if1.out_data, q1[0].dat);
      chk("out_lane1", if1.out_lane, q1[0].lane);
      chk("out_last1", if1.out_last, q1[0].last);
    end
    hs_in  = in_valid && exp_rdy;
    hs_out = vld && out_ready;
    @(posedge clk);
    err_exp = hs_in && (in_mode == 2'b11);
    if (hs_out) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
    end
    if (hs_in && in_mode != 2'b11) push_word(in_word, in_mode);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {if1.out_valid, if0.out_valid}, 32'd0);
    chk({tag, "_data"}, if0.out_data | if1.out_data, 32'd0);
    chk({tag, "_lane"}, {if1.out_lane, if0.out_lane}, 32'd0);
    chk({tag, "_last"}, {if1.out_last, if0.out_last}, 32'd0);
    chk({tag, "_err"}, {if1.err_mode, if0.err_mode}, 32'd0);
    chk({tag, "_rdy"}, {if1.in_ready, if0.in_ready}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_word = '0; in_mode = 2'b00; out_ready = 1'b1;
    err_exp = 1'b0;
    #2;
    chk_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // word mode, single beat
    in_valid = 1'b1; in_word = 32'hDEADBEEF; in_mode = 2'b00;
    step();
    in_valid = 1'b0;
    step(); step();

    // byte mode, four beats at full rate
    in_valid = 1'b1; in_mode = 2'b10;
    step();
    in_valid = 1'b0;
    repeat (5) step();

    // half mode with a three-cycle stall on the first beat
    in_valid = 1'b1; in_word = 32'h12345678; in_mode = 2'b01;
    step();
    in_valid = 1'b0; out_ready = 1'b0; in_word = 32'h0; in_mode = 2'b10;
    repeat (3) step();
    out_ready = 1'b1;
    repeat (3) step();

    // back-to-back: word offered during the last byte beat
    in_valid = 1'b1; in_word = 32'h01020304; in_mode = 2'b10;
    step();
    in_word = 32'hCAFEF00D; in_mode = 2'b00;
    repeat (4) step();
    in_valid = 1'b0;
    repeat (2) step();

    // reserved mode
    in_valid = 1'b1; in_word = 32'hAABBCCDD; in_mode = 2'b11;
    step();
    in_valid = 1'b0;
    repeat (3) step();

    // reset during the second byte beat
    in_valid = 1'b1; in_word = 32'hDEADBEEF; in_mode = 2'b10;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    q0.delete(); q1.delete(); err_exp = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) step();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_word   = $urandom;
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
